// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the oversampling UART receiver
package uart_pkg;

    localparam int DEFAULT_OS_RATE = 16;

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_EVEN = 2'b01,
        PAR_ODD  = 2'b10
    } parity_mode_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP1  = 3'd4,
        ST_STOP2  = 3'd5,
        ST_BRK    = 3'd6
    } rx_state_t;

    // The unused encoding 2'b11 behaves as "no parity".
    function automatic parity_mode_t decode_parity(input logic [1:0] mode);
        case (mode)
            2'b01:   return PAR_EVEN;
            2'b10:   return PAR_ODD;
            default: return PAR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - serial line synchroniser with 3-tap majority voter
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_rx,
    input  logic i_sample_en,
    output logic o_rx_sync,
    output logic o_vote
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [1:0]             tap_q, tap_d;

    // Shift the line through the synchroniser every cycle; record samples only on ticks.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], i_rx};
        tap_d  = tap_q;
        if (i_sample_en) begin
            tap_d = {tap_q[0], sync_q[SYNC_STAGES-1]};
        end
    end

    // Idle-high reset so a reset never looks like a start edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q <= '1;
            tap_q  <= 2'b11;
        end else begin
            sync_q <= sync_d;
            tap_q  <= tap_d;
        end
    end

    assign o_rx_sync = sync_q[SYNC_STAGES-1];

    // The two stored taps plus the current synced sample form the 3-sample vote,
    // so the vote is ready on the tick that takes the third sample.
    assign o_vote = (tap_q[1] & tap_q[0]) | (tap_q[1] & o_rx_sync) | (tap_q[0] & o_rx_sync);

endmodule

// File: rtl/uart_rx_os.sv
// rtl/uart_rx_os.sv - oversampling UART receiver with parity, stop bits, break and overrun
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int OS_RATE     = DEFAULT_OS_RATE,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_os_tick,
    input  logic                  i_RX,
    input  logic [1:0]            i_parity_mode,
    input  logic                  i_stop2,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_parity_err,
    output logic                  o_frame_err,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic                  o_break,
    output logic                  o_overrun,
    input  logic                  i_err_clr,
    output logic                  o_busy
);

    localparam int CW = $clog2(OS_RATE);
    localparam int BW = $clog2(DATA_WIDTH + 1);

    localparam logic [CW-1:0] CNT_LAST = CW'(OS_RATE - 1);
    localparam logic [CW-1:0] CNT_VOTE = CW'(OS_RATE / 2 + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

    logic rx_sync;
    logic vote;

    uart_rx_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_rx        (i_RX),
        .i_sample_en (i_os_tick),
        .o_rx_sync   (rx_sync),
        .o_vote      (vote)
    );

    rx_state_t             state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic                  par_bit_q, par_bit_d;
    logic                  ferr_q, ferr_d;
    parity_mode_t          par_mode_q, par_mode_d;
    logic                  stop2_q, stop2_d;

    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  perr_q, perr_d;
    logic                  fout_q, fout_d;
    logic                  overrun_q, overrun_d;
    logic                  break_q, break_d;

    logic at_vote;
    logic at_last;
    logic break_cond;
    logic par_xor;
    logic par_err;
    logic word_done;
    logic brk_hit;

    assign at_vote    = (cnt_q == CNT_VOTE);
    assign at_last    = (cnt_q == CNT_LAST);
    assign break_cond = (shreg_q == '0) && ((par_mode_q == PAR_NONE) || !par_bit_q);
    assign par_xor    = (^shreg_q) ^ par_bit_q;
    assign par_err    = ((par_mode_q == PAR_EVEN) && par_xor) ||
                        ((par_mode_q == PAR_ODD)  && !par_xor);

    // Frame FSM: advances only on oversample ticks, votes once per bit at mid-bit.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        par_bit_d  = par_bit_q;
        ferr_d     = ferr_q;
        par_mode_d = par_mode_q;
        stop2_d    = stop2_q;
        word_done  = 1'b0;
        brk_hit    = 1'b0;
        if (i_os_tick) begin
            cnt_d = at_last ? '0 : cnt_q + CW'(1);
            case (state_q)
                ST_IDLE: begin
                    cnt_d = '0;
                    if (!rx_sync) begin
                        state_d    = ST_START;
                        bit_cnt_d  = '0;
                        par_bit_d  = 1'b0;
                        ferr_d     = 1'b0;
                        par_mode_d = decode_parity(i_parity_mode);
                        stop2_d    = i_stop2;
                    end
                end
                ST_START: begin
                    if (at_vote && vote) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (at_last) begin
                        state_d = ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (at_vote) begin
                        shreg_d = {vote, shreg_q[DATA_WIDTH-1:1]};
                    end
                    if (at_last) begin
                        if (bit_cnt_q == BIT_LAST) begin
                            bit_cnt_d = '0;
                            state_d   = (par_mode_q != PAR_NONE) ? ST_PARITY : ST_STOP1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + BW'(1);
                        end
                    end
                end
                ST_PARITY: begin
                    if (at_vote) begin
                        par_bit_d = vote;
                    end
                    if (at_last) begin
                        state_d = ST_STOP1;
                    end
                end
                ST_STOP1: begin
                    if (at_vote) begin
                        if (!vote && break_cond) begin
                            brk_hit = 1'b1;
                            state_d = ST_BRK;
                            cnt_d   = '0;
                        end else begin
                            ferr_d = ferr_q | ~vote;
                            if (!stop2_q) begin
                                word_done = 1'b1;
                                state_d   = ST_IDLE;
                                cnt_d     = '0;
                            end
                        end
                    end else if (at_last) begin
                        state_d = ST_STOP2;
                    end
                end
                ST_STOP2: begin
                    if (at_vote) begin
                        ferr_d    = ferr_q | ~vote;
                        word_done = 1'b1;
                        state_d   = ST_IDLE;
                        cnt_d     = '0;
                    end
                end
                ST_BRK: begin
                    cnt_d = '0;
                    if (rx_sync) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Output holding register: load on completion when free, drop and flag overrun when stalled.
    always_comb begin
        valid_d   = valid_q;
        data_d    = data_q;
        perr_d    = perr_q;
        fout_d    = fout_q;
        overrun_d = i_err_clr ? 1'b0 : overrun_q;
        break_d   = brk_hit;
        if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end
        if (word_done) begin
            if (!valid_q || i_ready) begin
                valid_d = 1'b1;
                data_d  = shreg_q;
                perr_d  = par_err;
                fout_d  = ferr_d;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    // State and output registers; reset abandons any frame in flight.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            par_bit_q  <= 1'b0;
            ferr_q     <= 1'b0;
            par_mode_q <= PAR_NONE;
            stop2_q    <= 1'b0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            perr_q     <= 1'b0;
            fout_q     <= 1'b0;
            overrun_q  <= 1'b0;
            break_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            par_bit_q  <= par_bit_d;
            ferr_q     <= ferr_d;
            par_mode_q <= par_mode_d;
            stop2_q    <= stop2_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            perr_q     <= perr_d;
            fout_q     <= fout_d;
            overrun_q  <= overrun_d;
            break_q    <= break_d;
        end
    end

    assign o_data       = data_q;
    assign o_parity_err = perr_q;
    assign o_frame_err  = fout_q;
    assign o_valid      = valid_q;
    assign o_break      = break_q;
    assign o_overrun    = overrun_q;
    assign o_busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// tb/tb_uart_rx_os.sv - scoreboard bench for uart_rx_os
module tb_uart_rx_os;

    localparam int DW       = 8;
    localparam int OS       = 16;
    localparam int TICK_DIV = 13;
    localparam int BIT_CYC  = OS * TICK_DIV;

    logic          i_clk         = 1'b0;
    logic          i_rst         = 1'b1;
    logic          i_os_tick     = 1'b0;
    logic          i_RX          = 1'b1;
    logic [1:0]    i_parity_mode = 2'b00;
    logic          i_stop2       = 1'b0;
    logic          i_ready       = 1'b1;
    logic          i_err_clr     = 1'b0;
    logic [DW-1:0] o_data;
    logic          o_parity_err;
    logic          o_frame_err;
    logic          o_valid;
    logic          o_break;
    logic          o_overrun;
    logic          o_busy;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          perr;
        logic          ferr;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   n_acc = 0;
    int   n_brk = 0;

    uart_rx_os #(
        .DATA_WIDTH  (DW),
        .OS_RATE     (OS),
        .SYNC_STAGES (2)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_os_tick     (i_os_tick),
        .i_RX          (i_RX),
        .i_parity_mode (i_parity_mode),
        .i_stop2       (i_stop2),
        .o_data        (o_data),
        .o_parity_err  (o_parity_err),
        .o_frame_err   (o_frame_err),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_break       (o_break),
        .o_overrun     (o_overrun),
        .i_err_clr     (i_err_clr),
        .o_busy        (o_busy)
    );

    always #20 i_clk = ~i_clk;

    initial begin : tick_gen
        int tcnt;
        tcnt = 0;
        forever begin
            @(negedge i_clk);
            i_os_tick = (tcnt == 0);
            tcnt = (tcnt == TICK_DIV - 1) ? 0 : tcnt + 1;
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge i_clk);
            #1;
            if (o_break === 1'b1) n_brk++;
            if (o_valid === 1'b1 && i_ready === 1'b1) begin
                n_acc++;
                n_cmp++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_word: got data=%h perr=%b ferr=%b, required no word", o_data, o_parity_err, o_frame_err);
                end else begin
                    e = sb_q.pop_front();
                    if ({o_data, o_parity_err, o_frame_err} !== e) begin
                        n_fail++;
                        $display("FAIL word: got data=%h perr=%b ferr=%b, required data=%h perr=%b ferr=%b",
                                 o_data, o_parity_err, o_frame_err, e.data, e.perr, e.ferr);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        repeat (95000) @(negedge i_clk);
        $display("FAIL watchdog: simulation exceeded cycle budget, required completion");
        $fatal(1, "watchdog expired");
    end

    // par: 0 none, 1 even, 2 odd. abort_cyc > 0 stops driving after that many cycles.
    task automatic drive_frame(input logic [DW-1:0] data, input int par, input bit par_inv,
                               input int nstop, input bit s1, input bit s2, input int abort_cyc);
        logic [11:0] bits;
        int n;
        bits = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < DW; i++) bits[1 + i] = data[i];
        n = DW + 1;
        if (par != 0) begin
            bits[n] = ((par == 1) ? ^data : ~^data) ^ par_inv;
            n++;
        end
        bits[n] = s1;
        n++;
        if (nstop == 2) begin
            bits[n] = s2;
            n++;
        end
        for (int b = 0; b < n; b++) begin
            for (int c = 0; c < BIT_CYC; c++) begin
                if (abort_cyc > 0 && b * BIT_CYC + c == abort_cyc) return;
                @(negedge i_clk);
                i_RX = bits[b];
            end
        end
        @(negedge i_clk);
        i_RX = 1'b1;
        repeat (BIT_CYC) @(negedge i_clk);
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        repeat (5) @(negedge i_clk);
        i_rst = 1'b0;
        #1;
        n_cmp++; if (o_valid !== 1'b0)      begin n_fail++; $display("FAIL reset_valid: got %b, required 0", o_valid); end
        n_cmp++; if (o_data !== '0)         begin n_fail++; $display("FAIL reset_data: got %h, required 00", o_data); end
        n_cmp++; if (o_parity_err !== 1'b0) begin n_fail++; $display("FAIL reset_perr: got %b, required 0", o_parity_err); end
        n_cmp++; if (o_frame_err !== 1'b0)  begin n_fail++; $display("FAIL reset_ferr: got %b, required 0", o_frame_err); end
        n_cmp++; if (o_break !== 1'b0)      begin n_fail++; $display("FAIL reset_break: got %b, required 0", o_break); end
        n_cmp++; if (o_overrun !== 1'b0)    begin n_fail++; $display("FAIL reset_overrun: got %b, required 0", o_overrun); end
        n_cmp++; if (o_busy !== 1'b0)       begin n_fail++; $display("FAIL reset_busy: got %b, required 0", o_busy); end
        repeat (BIT_CYC) @(negedge i_clk);
    endtask

    task automatic test_8n1();
        int acc0;
        acc0 = n_acc;
        i_parity_mode = 2'b00; i_stop2 = 1'b0; i_ready = 1'b1;
        sb_q.push_back('{data: 8'hA5, perr: 1'b0, ferr: 1'b0});
        drive_frame(8'hA5, 0, 1'b0, 1, 1'b1, 1'b0, 0);
        for (int i = 0; i < 500 && sb_q.size() != 0; i++) @(negedge i_clk);
        #1;
        n_cmp++; if (n_acc - acc0 !== 1) begin n_fail++; $display("FAIL 8n1_count: got %0d words, required 1", n_acc - acc0); end
        n_cmp++; if (o_busy !== 1'b0)    begin n_fail++; $display("FAIL 8n1_busy: got %b, required 0", o_busy); end
    endtask

    task automatic test_parity();
        i_parity_mode = 2'b01; i_stop2 = 1'b0; i_ready = 1'b1;
        sb_q.push_back('{data: 8'h3C, perr: 1'b1, ferr: 1'b0});
        drive_frame(8'h3C, 1, 1'b1, 1, 1'b1, 1'b0, 0);
        sb_q.push_back('{data: 8'h3C, perr: 1'b0, ferr: 1'b0});
        drive_frame(8'h3C, 1, 1'b0, 1, 1'b1, 1'b0, 0);
        for (int i = 0; i < 500 && sb_q.size() != 0; i++) @(negedge i_clk);
        n_cmp++; if (sb_q.size() !== 0) begin n_fail++; $display("FAIL parity_drain: got %0d pending, required 0", sb_q.size()); end
    endtask

    task automatic test_glitch();
        int acc0, brk0;
        acc0 = n_acc; brk0 = n_brk;
        i_parity_mode = 2'b00; i_stop2 = 1'b0; i_ready = 1'b1;
        @(negedge i_clk);
        i_RX = 1'b0;
        repeat (4 * TICK_DIV) @(negedge i_clk);
        #1;
        n_cmp++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL glitch_seen: got busy=%b, required 1", o_busy); end
        i_RX = 1'b1;
        repeat (BIT_CYC - 4 * TICK_DIV) @(negedge i_clk);
        #1;
        n_cmp++; if (o_busy !== 1'b0)      begin n_fail++; $display("FAIL glitch_busy: got %b, required 0", o_busy); end
        n_cmp++; if (n_acc - acc0 !== 0)   begin n_fail++; $display("FAIL glitch_words: got %0d, required 0", n_acc - acc0); end
        n_cmp++; if (n_brk - brk0 !== 0)   begin n_fail++; $display("FAIL glitch_break: got %0d, required 0", n_brk - brk0); end
        sb_q.push_back('{data: 8'h5A, perr: 1'b0, ferr: 1'b0});
        drive_frame(8'h5A, 0, 1'b0, 1, 1'b1, 1'b0, 0);
        for (int i = 0; i < 500 && sb_q.size() != 0; i++) @(negedge i_clk);
        n_cmp++; if (sb_q.size() !== 0) begin n_fail++; $display("FAIL glitch_drain: got %0d pending, required 0", sb_q.size()); end
    endtask

    task automatic test_frame_break();
        int acc0, brk0;
        i_parity_mode = 2'b00; i_stop2 = 1'b0; i_ready = 1'b1;
        sb_q.push_back('{data: 8'h55, perr: 1'b0, ferr: 1'b1});
        drive_frame(8'h55, 0, 1'b0, 1, 1'b0, 1'b0, 0);
        for (int i = 0; i < 500 && sb_q.size() != 0; i++) @(negedge i_clk);
        n_cmp++; if (sb_q.size() !== 0) begin n_fail++; $display("FAIL frame_drain: got %0d pending, required 0", sb_q.size()); end
        acc0 = n_acc; brk0 = n_brk;
        @(negedge i_clk);
        i_RX = 1'b0;
        repeat (20 * BIT_CYC) @(negedge i_clk);
        i_RX = 1'b1;
        repeat (BIT_CYC) @(negedge i_clk);
        #1;
        n_cmp++; if (n_brk - brk0 !== 1) begin n_fail++; $display("FAIL break_pulses: got %0d, required 1", n_brk - brk0); end
        n_cmp++; if (n_acc - acc0 !== 0) begin n_fail++; $display("FAIL break_words: got %0d, required 0", n_acc - acc0); end
        n_cmp++; if (o_busy !== 1'b0)    begin n_fail++; $display("FAIL break_busy: got %b, required 0", o_busy); end
        sb_q.push_back('{data: 8'h81, perr: 1'b0, ferr: 1'b0});
        drive_frame(8'h81, 0, 1'b0, 1, 1'b1, 1'b0, 0);
        for (int i = 0; i < 500 && sb_q.size() != 0; i++) @(negedge i_clk);
        n_cmp++; if (sb_q.size() !== 0) begin n_fail++; $display("FAIL break_after_drain: got %0d pending, required 0", sb_q.size()); end
    endtask

    task automatic test_overrun();
        int acc0;
        i_parity_mode = 2'b00; i_stop2 = 1'b0; i_ready = 1'b0;
        acc0 = n_acc;
        sb_q.push_back('{data: 8'h11, perr: 1'b0, ferr: 1'b0});
        drive_frame(8'h11, 0, 1'b0, 1, 1'b1, 1'b0, 0);
        drive_frame(8'h22, 0, 1'b0, 1, 1'b1, 1'b0, 0);
        #1;
        n_cmp++; if (o_valid !== 1'b1)   begin n_fail++; $display("FAIL ovr_valid: got %b, required 1", o_valid); end
        n_cmp++; if (o_data !== 8'h11)   begin n_fail++; $display("FAIL ovr_held: got %h, required 11", o_data); end
        n_cmp++; if (o_overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %b, required 1", o_overrun); end
        @(negedge i_clk); i_ready = 1'b1;
        @(negedge i_clk); i_ready = 1'b0;
        @(negedge i_clk); #1;
        n_cmp++; if (o_valid !== 1'b0)     begin n_fail++; $display("FAIL ovr_release: got valid=%b, required 0", o_valid); end
        n_cmp++; if (n_acc - acc0 !== 1)   begin n_fail++; $display("FAIL ovr_accepts: got %0d, required 1", n_acc - acc0); end
        i_err_clr = 1'b1;
        @(negedge i_clk); i_err_clr = 1'b0;
        #1;
        n_cmp++; if (o_overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: got %b, required 0", o_overrun); end
        sb_q.push_back('{data: 8'h33, perr: 1'b0, ferr: 1'b0});
        drive_frame(8'h33, 0, 1'b0, 1, 1'b1, 1'b0, 0);
        i_err_clr = 1'b1;
        fork
            drive_frame(8'h44, 0, 1'b0, 1, 1'b1, 1'b0, 0);
            begin
                for (int k = 0; k < 4000; k++) begin
                    @(negedge i_clk);
                    if (o_overrun === 1'b1) begin
                        i_err_clr = 1'b0;
                        break;
                    end
                end
            end
        join
        i_err_clr = 1'b0;
        @(negedge i_clk); #1;
        n_cmp++; if (o_overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set_wins: got %b, required 1", o_overrun); end
        n_cmp++; if (o_data !== 8'h33)   begin n_fail++; $display("FAIL ovr_held2: got %h, required 33", o_data); end
        i_ready = 1'b1;
        for (int i = 0; i < 500 && sb_q.size() != 0; i++) @(negedge i_clk);
        n_cmp++; if (sb_q.size() !== 0) begin n_fail++; $display("FAIL ovr_drain: got %0d pending, required 0", sb_q.size()); end
        i_err_clr = 1'b1;
        @(negedge i_clk); i_err_clr = 1'b0;
    endtask

    task automatic test_stop2_reset();
        i_parity_mode = 2'b10; i_stop2 = 1'b1; i_ready = 1'b1;
        sb_q.push_back('{data: 8'hFF, perr: 1'b0, ferr: 1'b1});
        drive_frame(8'hFF, 2, 1'b0, 2, 1'b1, 1'b0, 0);
        for (int i = 0; i < 500 && sb_q.size() != 0; i++) @(negedge i_clk);
        n_cmp++; if (sb_q.size() !== 0) begin n_fail++; $display("FAIL stop2_drain: got %0d pending, required 0", sb_q.size()); end
        i_parity_mode = 2'b00; i_stop2 = 1'b0;
        drive_frame(8'hC3, 0, 1'b0, 1, 1'b1, 1'b0, 5 * BIT_CYC + BIT_CYC / 2);
        #1;
        n_cmp++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL rst_midframe_busy: got %b, required 1", o_busy); end
        @(negedge i_clk);
        i_rst = 1'b1; i_RX = 1'b1;
        repeat (3) @(negedge i_clk);
        i_rst = 1'b0;
        #1;
        n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b, required 0", o_valid); end
        n_cmp++; if (o_busy !== 1'b0)  begin n_fail++; $display("FAIL rst_busy: got %b, required 0", o_busy); end
        repeat (BIT_CYC) @(negedge i_clk);
        sb_q.push_back('{data: 8'hC3, perr: 1'b0, ferr: 1'b0});
        drive_frame(8'hC3, 0, 1'b0, 1, 1'b1, 1'b0, 0);
        for (int i = 0; i < 500 && sb_q.size() != 0; i++) @(negedge i_clk);
        n_cmp++; if (sb_q.size() !== 0) begin n_fail++; $display("FAIL rst_after_drain: got %0d pending, required 0", sb_q.size()); end
    endtask

    initial begin : main
        test_reset();
        test_8n1();
        test_parity();
        test_glitch();
        test_frame_break();
        test_overrun();
        test_stop2_reset();
        repeat (20) @(negedge i_clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
